// File: rtl/rhs2116_seq_master.sv
// SPI sequencer for the RHS2116: round-robin CONVERT polling over enabled channels plus a host one-shot command port.
// Optional feature: define RHS_SEQ_SWEEP_CNT_EN to build the completed-sweep counter driving sweep_cnt.
module rhs2116_seq_master #(
    parameter int CLK_DIV       = 2,
    parameter int CS_GAP_CYCLES = 16,
    parameter int NUM_CH        = 16,
    parameter int PIPE_DEPTH    = 2
) (
    input  logic        clk_spi,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] ch_mask,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_data,
    output logic        cmd_ready,
    output logic        cs_n,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic [4:0]  rx_tag,
    output logic        busy,
    output logic [15:0] sweep_cnt
);
    typedef enum logic [1:0] {IDLE, LOAD, TRANS, GAP} state_t;

    localparam logic [15:0] CH_VALID = 16'((32'd1 << NUM_CH) - 32'd1);
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(CS_GAP_CYCLES - 1);
    localparam logic [4:0]  NUM_CH5  = 5'(NUM_CH);
    localparam logic [3:0]  LAST_CH  = 4'(NUM_CH - 1);
    localparam logic [2:0]  PIPE3    = 3'(PIPE_DEPTH);

    state_t      state, state_nxt;
    logic [15:0] eff_mask, div_cnt, gap_cnt;
    logic [4:0]  bit_cnt, idx, cur_tag;
    logic [3:0]  ptr, ptr_nxt, sel_ch;
    logic [4:0]  tag_pipe [PIPE_DEPTH];
    logic [2:0]  frame_cnt;
    logic [30:0] tx_shift, rx_shift;
    logic [31:0] conv_word;
    logic        sel_found, poll_req, div_done, last_edge, conv_load, host_load;

    assign eff_mask  = ch_mask & CH_VALID;
    assign poll_req  = enable && (eff_mask != 16'h0000);
    assign host_load = (state == LOAD) && cmd_valid;
    assign conv_load = (state == LOAD) && !cmd_valid && enable && sel_found;
    assign cmd_ready = host_load;
    assign busy      = (state != IDLE);
    assign div_done  = (div_cnt == DIV_LAST);
    assign last_edge = (state == TRANS) && div_done && !sclk && (bit_cnt == 5'd31);
    assign conv_word = {4'b0000, 1'b1, 1'b0, 4'b0000, 2'b00, sel_ch, 16'h0000};
    assign ptr_nxt   = (sel_ch == LAST_CH) ? 4'h0 : sel_ch + 4'h1;

    // Circular search for the first enabled channel starting at the poll pointer.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = 4'h0;
        idx       = 5'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = {1'b0, ptr} + 5'(i);
            if (idx >= NUM_CH5) idx = idx - NUM_CH5;
            if (!sel_found && eff_mask[idx[3:0]]) begin
                sel_found = 1'b1;
                sel_ch    = idx[3:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid || poll_req) state_nxt = LOAD;
            LOAD:    state_nxt = (host_load || conv_load) ? TRANS : IDLE;
            TRANS:   if (last_edge) state_nxt = GAP;
            GAP:     if (gap_cnt == GAP_LAST) state_nxt = (cmd_valid || poll_req) ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_spi or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk_spi or negedge rst_n) begin
        if (!rst_n) begin
            cs_n      <= 1'b1;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= 32'h0;
            rx_tag    <= 5'h00;
            ptr       <= 4'h0;
            div_cnt   <= 16'h0;
            gap_cnt   <= 16'h0;
            bit_cnt   <= 5'h00;
            cur_tag   <= 5'h00;
            frame_cnt <= 3'h0;
            tx_shift  <= 31'h0;
            rx_shift  <= 31'h0;
            for (int i = 0; i < PIPE_DEPTH; i++) tag_pipe[i] <= 5'h00;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    frame_cnt <= 3'h0;
                    for (int i = 0; i < PIPE_DEPTH; i++) tag_pipe[i] <= 5'h00;
                end
                LOAD: if (host_load || conv_load) begin
                    cs_n    <= 1'b0;
                    sclk    <= 1'b0;
                    div_cnt <= 16'h0;
                    bit_cnt <= 5'h00;
                    if (host_load) begin
                        tx_shift <= cmd_data[30:0];
                        mosi     <= cmd_data[31];
                        cur_tag  <= 5'h10;
                    end else begin
                        tx_shift <= conv_word[30:0];
                        mosi     <= conv_word[31];
                        cur_tag  <= {1'b0, sel_ch};
                        ptr      <= ptr_nxt;
                    end
                end
                TRANS: if (!div_done) begin
                    div_cnt <= div_cnt + 16'h1;
                end else begin
                    div_cnt <= 16'h0;
                    sclk    <= ~sclk;
                    if (!sclk) begin
                        rx_shift <= {rx_shift[29:0], miso};
                        bit_cnt  <= bit_cnt + 5'h01;
                        // Frame end: results lag the request by PIPE_DEPTH frames, so report the oldest tag.
                        if (bit_cnt == 5'd31) begin
                            gap_cnt <= 16'h0;
                            if (frame_cnt >= PIPE3) begin
                                rx_valid <= 1'b1;
                                rx_data  <= {rx_shift, miso};
                                rx_tag   <= tag_pipe[PIPE_DEPTH-1];
                            end else begin
                                frame_cnt <= frame_cnt + 3'h1;
                            end
                            tag_pipe[0] <= cur_tag;
                            for (int i = 1; i < PIPE_DEPTH; i++) tag_pipe[i] <= tag_pipe[i-1];
                        end
                    end else begin
                        tx_shift <= {tx_shift[29:0], 1'b0};
                        mosi     <= tx_shift[30];
                    end
                end
                GAP: begin
                    cs_n <= 1'b1;
                    sclk <= 1'b0;
                    mosi <= 1'b0;
                    if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 16'h1;
                end
                default: ;
            endcase
        end
    end

`ifdef RHS_SEQ_SWEEP_CNT_EN
    logic [15:0] sweep_q;

    // A sweep completes whenever the pointer moves back to a lower-or-equal channel.
    always_ff @(posedge clk_spi or negedge rst_n) begin
        if (!rst_n)                            sweep_q <= 16'h0;
        else if (conv_load && ptr_nxt <= ptr) sweep_q <= sweep_q + 16'h1;
    end

    assign sweep_cnt = sweep_q;
`else
    assign sweep_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rhs2116_seq_master.sv
// Directed bench for rhs2116_seq_master: echo-slave SPI model, polling/command/disable/reset scenarios.
module tb_rhs2116_seq_master;
    localparam int NUM_CH = 4;
    localparam int PIPE   = 2;
    localparam int GAPC   = 16;

    logic        clk_spi = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] ch_mask = 16'h0;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_data = 32'h0;
    logic        miso = 1'b0;
    logic        cmd_ready, cs_n, sclk, mosi, rx_valid, busy;
    logic [31:0] rx_data;
    logic [4:0]  rx_tag;
    logic [15:0] sweep_cnt;

    int          n_checks = 0;
    int          n_fails = 0;
    int          frame_start_cnt = 0;
    int          slv_bits = 0;
    int          last_bits = 0;
    int          rdy_cnt = 0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    logic [31:0] slv_tx = 32'h0;
    logic [31:0] slv_rx = 32'h0;
    logic [31:0] hist[$];
    logic [31:0] rx_data_q[$];
    logic [4:0]  rx_tag_q[$];
    time         t_cs_rise = 0;
    time         t_busy_fall = 0;
    time         last_gap = 0;
    int          mdl_p = 0;
    int          mdl_sweep = 0;

    rhs2116_seq_master #(
        .CLK_DIV(2), .CS_GAP_CYCLES(GAPC), .NUM_CH(NUM_CH), .PIPE_DEPTH(PIPE)
    ) dut (
        .clk_spi(clk_spi), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_tag(rx_tag),
        .busy(busy), .sweep_cnt(sweep_cnt)
    );

    always #5 clk_spi = ~clk_spi;

    // Echo slave: answers each frame with the word it received two completed frames earlier.
    always @(cs_n or sclk) begin
        if (cs_n !== prev_cs) begin
            if (cs_n === 1'b0) begin
                frame_start_cnt++;
                slv_bits = 0;
                slv_rx   = 32'h0;
                last_gap = $time - t_cs_rise;
                slv_tx   = (hist.size() >= 2) ? hist[hist.size()-2] : 32'h0;
                miso     = slv_tx[31];
            end else if (cs_n === 1'b1) begin
                t_cs_rise = $time;
                last_bits = slv_bits;
                if (slv_bits == 32) hist.push_back(slv_rx);
            end
        end else if (sclk !== prev_sclk && cs_n === 1'b0) begin
            if (sclk === 1'b1) begin
                slv_rx = {slv_rx[30:0], mosi};
                slv_bits++;
            end else if (sclk === 1'b0) begin
                slv_tx = {slv_tx[30:0], 1'b0};
                miso   = slv_tx[31];
            end
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
    end

    always @(negedge clk_spi) begin
        if (rx_valid === 1'b1) begin
            rx_data_q.push_back(rx_data);
            rx_tag_q.push_back(rx_tag);
        end
        if (cmd_ready === 1'b1) rdy_cnt++;
    end

    always @(negedge busy) t_busy_fall = $time;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] convWord(input logic [3:0] c);
        return 32'h0800_0000 | (32'(c) << 16);
    endfunction

    task automatic mdlConvert(input logic [15:0] mask, output logic [3:0] ch);
        int c;
        int np;
        c = -1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (c < 0 && mask[(mdl_p + i) % NUM_CH]) c = (mdl_p + i) % NUM_CH;
        end
        np = (c + 1) % NUM_CH;
        if (np <= mdl_p) mdl_sweep++;
        mdl_p = np;
        ch = 4'(c);
    endtask

    task automatic checkResetState(input string pfx);
        checkOutput({pfx, "_cs_n"}, cs_n, 1);
        checkOutput({pfx, "_sclk"}, sclk, 0);
        checkOutput({pfx, "_mosi"}, mosi, 0);
        checkOutput({pfx, "_cmd_ready"}, cmd_ready, 0);
        checkOutput({pfx, "_rx_valid"}, rx_valid, 0);
        checkOutput({pfx, "_rx_data"}, rx_data, 0);
        checkOutput({pfx, "_rx_tag"}, rx_tag, 0);
        checkOutput({pfx, "_busy"}, busy, 0);
        checkOutput({pfx, "_sweep"}, sweep_cnt, 0);
    endtask

    // Poll with the given mask for nframes frames, optionally injecting a host command as frame cmd_at.
    task automatic applyStimulus(input logic [15:0] mask, input int nframes, input int cmd_at);
        logic [31:0] exp_word[$];
        logic [4:0]  exp_tag[$];
        logic [3:0]  c;
        int          fb, hb, rb, cb, exp_sweep;
        bit          ok, cmd_sent, clear_pending;
        for (int i = 0; i < nframes; i++) begin
            if (i == cmd_at) begin
                exp_word.push_back(32'h80AA_1234);
                exp_tag.push_back(5'h10);
            end else begin
                mdlConvert(mask, c);
                exp_word.push_back(convWord(c));
                exp_tag.push_back({1'b0, c});
            end
        end
        fb = frame_start_cnt;
        hb = hist.size();
        rb = rx_tag_q.size();
        cb = rdy_cnt;
        cmd_sent = 0;
        clear_pending = 0;
        ok = 0;
        @(negedge clk_spi);
        ch_mask = mask;
        enable  = 1'b1;
        for (int cyc = 0; cyc < nframes * 400; cyc++) begin
            @(negedge clk_spi);
            if (clear_pending) begin
                cmd_valid = 1'b0;
                clear_pending = 0;
            end
            if (cmd_valid && cmd_ready) clear_pending = 1;
            if (cmd_at > 0 && !cmd_sent && frame_start_cnt - fb == cmd_at) begin
                cmd_data  = 32'h80AA_1234;
                cmd_valid = 1'b1;
                cmd_sent  = 1;
            end
            if (frame_start_cnt - fb >= nframes && !cmd_valid) begin
                ok = 1;
                break;
            end
        end
        checkOutput("frames_started", 32'(ok), 1);
        ok = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk_spi);
            if (slv_bits >= 10) begin
                ok = 1;
                break;
            end
        end
        enable = 1'b0;
        checkOutput("disable_mid_frame", 32'(ok), 1);
        ok = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk_spi);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        checkOutput("idle_reached", 32'(ok), 1);
        checkOutput("cs_n_idle", cs_n, 1);
        checkOutput("last_frame_bits", 32'(last_bits), 32);
        checkOutput("cs_gap_time", 32'(last_gap), GAPC * 10);
        checkOutput("busy_drop_time", 32'(t_busy_fall - t_cs_rise), (GAPC - 1) * 10);
        checkOutput("n_frames", 32'(hist.size() - hb), 32'(nframes));
        for (int i = 0; i < nframes; i++) begin
            if (hb + i < hist.size()) checkOutput($sformatf("mosi_frame%0d", i), hist[hb+i], exp_word[i]);
        end
        checkOutput("n_rx", 32'(rx_tag_q.size() - rb), 32'(nframes - PIPE));
        for (int i = 0; i < nframes - PIPE; i++) begin
            if (rb + i < rx_tag_q.size()) begin
                checkOutput($sformatf("rx_tag%0d", i), 32'(rx_tag_q[rb+i]), 32'(exp_tag[i]));
                checkOutput($sformatf("rx_data%0d", i), rx_data_q[rb+i], exp_word[i]);
            end
        end
        checkOutput("cmd_ready_pulses", 32'(rdy_cnt - cb), (cmd_at > 0) ? 1 : 0);
`ifdef RHS_SEQ_SWEEP_CNT_EN
        exp_sweep = mdl_sweep;
`else
        exp_sweep = 0;
`endif
        checkOutput("sweep_cnt", 32'(sweep_cnt), 32'(exp_sweep));
    endtask

    initial begin
        int fb, rb;
        bit ok;
        #22;
        checkResetState("por");
        @(negedge clk_spi);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_spi);

        $display("[TB] full mask polling, channels 0..3");
        applyStimulus(16'h000F, 6, -1);
        $display("[TB] sparse mask 0x0A");
        applyStimulus(16'h000A, 6, -1);
        $display("[TB] host command during polling");
        applyStimulus(16'h000F, 5, 1);

        $display("[TB] only out-of-range mask bits set");
        fb = frame_start_cnt;
        @(negedge clk_spi);
        ch_mask = 16'hFFF0;
        enable  = 1'b1;
        repeat (60) @(negedge clk_spi);
        checkOutput("zero_mask_busy", busy, 0);
        checkOutput("zero_mask_frames", 32'(frame_start_cnt - fb), 0);
        enable = 1'b0;

        $display("[TB] reset in the middle of a frame");
        fb = frame_start_cnt;
        rb = rx_tag_q.size();
        @(negedge clk_spi);
        ch_mask = 16'h000F;
        enable  = 1'b1;
        ok = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk_spi);
            if (frame_start_cnt > fb && slv_bits >= 20) begin
                ok = 1;
                break;
            end
        end
        checkOutput("reach_bit20", 32'(ok), 1);
        rst_n = 1'b0;
        #1;
        checkResetState("midrst");
        checkOutput("midrst_no_rx", 32'(rx_tag_q.size() - rb), 0);
        enable = 1'b0;
        mdl_p = 0;
        mdl_sweep = 0;
        repeat (3) @(negedge clk_spi);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_spi);

        $display("[TB] restart after reset");
        applyStimulus(16'h000F, 3, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
